// File: rtl/mcyc_ctrl_pkg.sv
// Shared encodings for the MCycMIPS32 multi-cycle control unit: FSM states,
// opcode/funct values, ALU operations and datapath mux selects.
package mcyc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JR, S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] SRCB_REGB    = 3'd0;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;
  localparam logic [2:0] SRCB_FOUR    = 3'd4;
  localparam logic [2:0] SRCB_ZIMM    = 3'd5;

  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_REGA   = 3'd3;

  function automatic logic is_itype_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mcyc_alu_decode.sv
// Combinational op/func to ALU operation map for R-type and immediate ALU
// instructions; supported_o drops for anything the ALU cannot execute.
module mcyc_alu_decode
  import mcyc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic [3:0] aluop_o,
  output logic       supported_o
);

  always_comb begin
    aluop_o     = ALU_ADD;
    supported_o = 1'b1;
    if (op_i == OP_RTYPE) begin
      case (func_i)
        FN_ADD, FN_ADDU: aluop_o = ALU_ADD;
        FN_SUB, FN_SUBU: aluop_o = ALU_SUB;
        FN_AND:          aluop_o = ALU_AND;
        FN_OR:           aluop_o = ALU_OR;
        FN_XOR:          aluop_o = ALU_XOR;
        FN_NOR:          aluop_o = ALU_NOR;
        FN_SLT:          aluop_o = ALU_SLT;
        default:         supported_o = 1'b0;
      endcase
    end else begin
      case (op_i)
        OP_ADDI, OP_ADDIU: aluop_o = ALU_ADD;
        OP_SLTI:           aluop_o = ALU_SLT;
        OP_ANDI:           aluop_o = ALU_AND;
        OP_ORI:            aluop_o = ALU_OR;
        default:           supported_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mcyc_control_fsm.sv
// Moore control FSM for the multi-cycle MIPS32 datapath; memory states stall
// on mem_ready and every completed instruction bumps instr_retired.
module mcyc_control_fsm
  import mcyc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        mdr_we,
  output logic        rega_we,
  output logic        regb_we,
  output logic        aluout_we,
  output logic        reg_write,
  output logic        pc_we,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic        iord,
  output logic [2:0]  alu_src_b,
  output logic [2:0]  pc_src,
  output logic [3:0]  aluop,
  output logic        illegal,
  output logic [31:0] instr_retired
);

  state_e      state_q, state_d;
  logic [31:0] instr_retired_q, instr_retired_d;
  logic        retire;
  logic [3:0]  dec_aluop;
  logic        dec_supported;

  mcyc_alu_decode u_alu_decode (
    .op_i        (op),
    .func_i      (func),
    .aluop_o     (dec_aluop),
    .supported_o (dec_supported)
  );

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    rega_we    = 1'b0;
    regb_we    = 1'b0;
    aluout_we  = 1'b0;
    reg_write  = 1'b0;
    pc_we      = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    iord       = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    aluop      = ALU_AND;
    illegal    = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        aluop     = ALU_ADD;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively for BRANCH to use.
        rega_we   = 1'b1;
        regb_we   = 1'b1;
        aluout_we = 1'b1;
        alu_src_b = SRCB_IMM_SH2;
        aluop     = ALU_ADD;
        case (op)
          OP_RTYPE: begin
            if (func == FN_JR) begin
              state_d = S_JR;
            end else if (func == FN_NOP) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = S_REXEC;
            end
          end
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = is_itype_alu(op) ? S_IEXEC : S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        aluop     = ALU_ADD;
        aluout_we = 1'b1;
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mdr_we  = mem_ready;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        aluop     = dec_aluop;
        aluout_we = 1'b1;
        state_d   = dec_supported ? S_RWB : S_HALT;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ((op == OP_ANDI) || (op == OP_ORI)) ? SRCB_ZIMM : SRCB_IMM;
        aluop     = dec_aluop;
        aluout_we = 1'b1;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        aluop     = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_we     = zero ^ (op == OP_BNE);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src  = PCSRC_REGA;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: illegal = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  assign instr_retired_d = retire ? instr_retired_q + 32'd1 : instr_retired_q;
  assign instr_retired   = instr_retired_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= S_RST;
      instr_retired_q <= '0;
    end else begin
      state_q         <= state_d;
      instr_retired_q <= instr_retired_d;
    end
  end

endmodule

// File: tb/tb_mcyc_control_fsm.sv
// Instruction-level bench for mcyc_control_fsm: each instruction pushes its
// expected cycle count, strobe pulse counts and mux selects, popped at retire.
module tb_mcyc_control_fsm;

  logic        clk;
  logic        nrst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_we, mdr_we, rega_we, regb_we, aluout_we;
  logic        reg_write, pc_we, mem_to_reg, reg_dst, alu_src_a, iord;
  logic [2:0]  alu_src_b;
  logic [2:0]  pc_src;
  logic [3:0]  aluop;
  logic        illegal;
  logic [31:0] instr_retired;

  mcyc_control_fsm dut (
    .clk(clk), .nrst(nrst), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .mdr_we(mdr_we), .rega_we(rega_we), .regb_we(regb_we),
    .aluout_we(aluout_we), .reg_write(reg_write), .pc_we(pc_we),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .iord(iord), .alu_src_b(alu_src_b), .pc_src(pc_src), .aluop(aluop),
    .illegal(illegal), .instr_retired(instr_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  logic [8:0]  enables;
  logic [23:0] all_out;
  assign enables = {mem_req, mem_we, ir_we, mdr_we, rega_we, regb_we,
                    aluout_we, reg_write, pc_we};
  assign all_out = {enables, mem_to_reg, reg_dst, alu_src_a, iord,
                    alu_src_b, pc_src, aluop, illegal};

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_ret = 32'd0;

  typedef struct {
    int cycles, ir, mdr, rw, pcwe, memwe, pcsrc, rdst, m2r, aluop, srca, srcb, ill;
    logic [31:0] ret;
  } rec_t;

  rec_t exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int r_aluop(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 2;
      6'h22, 6'h23: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h26: return 3;
      6'h27: return 12;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  function automatic int i_aluop(input logic [5:0] o);
    case (o)
      6'h08, 6'h09: return 2;
      6'h0A: return 7;
      6'h0C: return 0;
      6'h0D: return 1;
      default: return -1;
    endcase
  endfunction

  // Instruction-level reference: zero-wait cycle counts plus one per wait cycle.
  function automatic rec_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int fw, input int mw, input int extra,
                                 input logic [31:0] base);
    rec_t r;
    int taken;
    r = '{cycles: fw + extra, ir: 1, mdr: 0, rw: 0, pcwe: 1, memwe: 0, pcsrc: 0,
          rdst: 0, m2r: 0, aluop: 2, srca: 0, srcb: 3, ill: 0, ret: base + 32'd1};
    if (o == 6'h00 && f == 6'h00) begin
      r.cycles += 2;
    end else if (o == 6'h00 && f == 6'h08) begin
      r.cycles += 3; r.pcwe = 2; r.pcsrc = 3;
    end else if (o == 6'h00) begin
      r.cycles += 4; r.rw = 1; r.rdst = 1; r.aluop = r_aluop(f); r.srca = 1; r.srcb = 0;
    end else if (o == 6'h23) begin
      r.cycles += 5 + mw; r.mdr = 1; r.rw = 1; r.m2r = 1; r.srca = 1; r.srcb = 2;
    end else if (o == 6'h2B) begin
      r.cycles += 4 + mw; r.memwe = mw + 1; r.srca = 1; r.srcb = 2;
    end else if (o == 6'h04 || o == 6'h05) begin
      taken = int'(z ^ (o == 6'h05));
      r.cycles += 3; r.pcwe = 1 + taken; r.pcsrc = taken;
    end else if (o == 6'h02) begin
      r.cycles += 3; r.pcwe = 2; r.pcsrc = 2;
    end else begin
      r.cycles += 4; r.rw = 1; r.aluop = i_aluop(o); r.srca = 1;
      r.srcb = (o == 6'h0C || o == 6'h0D) ? 5 : 2;
    end
    return r;
  endfunction

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fw, input int mw, input int extra);
    rec_t e, g;
    int fw_left, mw_left;
    logic [31:0] ret0;
    bit done;
    e = model(o, f, z, fw, mw, extra, exp_ret);
    exp_q.push_back(e);
    exp_ret = e.ret;
    op = o; func = f; zero = z;
    fw_left = fw; mw_left = mw;
    ret0 = instr_retired;
    g = '{cycles: 0, ir: 0, mdr: 0, rw: 0, pcwe: 0, memwe: 0, pcsrc: 0,
          rdst: 0, m2r: 0, aluop: 0, srca: 0, srcb: 0, ill: 0, ret: 32'd0};
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (mem_req && !iord) begin
        if (fw_left > 0) begin mem_ready = 1'b0; fw_left--; end
        else mem_ready = 1'b1;
      end else if (mem_req && iord) begin
        if (mw_left > 0) begin mem_ready = 1'b0; mw_left--; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      g.cycles++;
      if (ir_we) g.ir++;
      if (mdr_we) g.mdr++;
      if (mem_we) g.memwe++;
      if (illegal) g.ill++;
      if (pc_we) begin g.pcwe++; g.pcsrc = int'(pc_src); end
      if (reg_write) begin g.rw++; g.rdst = int'(reg_dst); g.m2r = int'(mem_to_reg); end
      if (aluout_we) begin
        g.aluop = int'(aluop); g.srca = int'(alu_src_a); g.srcb = int'(alu_src_b);
      end
      @(posedge clk);
      #1;
      if (instr_retired !== ret0) done = 1'b1;
    end
    g.ret = instr_retired;
    check_val({name, ".retired_in_time"}, 32'(done), 32'd1);
    e = exp_q.pop_front();
    check_val({name, ".cycles"}, g.cycles, e.cycles);
    check_val({name, ".ir_we"}, g.ir, e.ir);
    check_val({name, ".mdr_we"}, g.mdr, e.mdr);
    check_val({name, ".reg_write"}, g.rw, e.rw);
    check_val({name, ".pc_we"}, g.pcwe, e.pcwe);
    check_val({name, ".mem_we"}, g.memwe, e.memwe);
    check_val({name, ".pc_src"}, g.pcsrc, e.pcsrc);
    check_val({name, ".reg_dst"}, g.rdst, e.rdst);
    check_val({name, ".mem_to_reg"}, g.m2r, e.m2r);
    check_val({name, ".aluop"}, g.aluop, e.aluop);
    check_val({name, ".alu_src_a"}, g.srca, e.srca);
    check_val({name, ".alu_src_b"}, g.srcb, e.srcb);
    check_val({name, ".illegal"}, g.ill, e.ill);
    check_val({name, ".instr_retired"}, g.ret, e.ret);
    $display("instr %-6s op=%02h func=%02h zero=%0d cycles=%0d retired=%0d",
             name, o, f, z, g.cycles, g.ret);
  endtask

  task automatic halt_test(input string name, input logic [5:0] o, input logic [5:0] f);
    bit reached;
    int viol;
    op = o; func = f;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      if (illegal) reached = 1'b1;
    end
    check_val({name, ".reached_halt"}, 32'(reached), 32'd1);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (enables != 9'd0 || !illegal) viol++;
    end
    check_val({name, ".halt_violations"}, viol, 0);
    check_val({name, ".halt_retired"}, instr_retired, exp_ret);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check_val({name, ".reset_outputs"}, 32'(all_out), 32'd0);
    check_val({name, ".reset_retired"}, instr_retired, 32'd0);
    exp_ret = 32'd0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    $display("halt   %-6s op=%02h func=%02h violations=%0d", name, o, f, viol);
  endtask

  initial begin
    int seen;
    nrst = 1'b0; op = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset.outputs", 32'(all_out), 32'd0);
    check_val("reset.retired", instr_retired, 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    run_instr("add",   6'h00, 6'h20, 1'b0, 0, 0, 1);
    run_instr("lw",    6'h23, 6'h00, 1'b0, 2, 1, 0);
    run_instr("sw",    6'h2B, 6'h00, 1'b1, 0, 2, 0);
    run_instr("beq_t", 6'h04, 6'h00, 1'b1, 0, 0, 0);
    run_instr("beq_n", 6'h04, 6'h00, 1'b0, 1, 0, 0);
    run_instr("bne_t", 6'h05, 6'h00, 1'b0, 0, 0, 0);
    run_instr("bne_n", 6'h05, 6'h00, 1'b1, 0, 0, 0);
    run_instr("j",     6'h02, 6'h11, 1'b0, 0, 0, 0);
    run_instr("jr",    6'h00, 6'h08, 1'b0, 3, 0, 0);
    run_instr("nop",   6'h00, 6'h00, 1'b0, 0, 0, 0);
    run_instr("addi",  6'h08, 6'h2A, 1'b0, 0, 0, 0);
    run_instr("addiu", 6'h09, 6'h00, 1'b0, 1, 0, 0);
    run_instr("slti",  6'h0A, 6'h00, 1'b0, 0, 0, 0);
    run_instr("andi",  6'h0C, 6'h00, 1'b0, 0, 0, 0);
    run_instr("ori",   6'h0D, 6'h24, 1'b0, 2, 0, 0);
    run_instr("subu",  6'h00, 6'h23, 1'b0, 0, 0, 0);
    run_instr("and",   6'h00, 6'h24, 1'b0, 0, 0, 0);
    run_instr("or",    6'h00, 6'h25, 1'b0, 0, 0, 0);
    run_instr("xor",   6'h00, 6'h26, 1'b0, 0, 0, 0);
    run_instr("nor",   6'h00, 6'h27, 1'b0, 0, 0, 0);
    run_instr("slt",   6'h00, 6'h2A, 1'b0, 1, 0, 0);
    run_instr("lw0",   6'h23, 6'h00, 1'b0, 0, 0, 0);

    halt_test("op3f", 6'h3F, 6'h00);
    halt_test("fn3f", 6'h00, 6'h3F);

    run_instr("j_rst", 6'h02, 6'h00, 1'b0, 0, 0, 1);

    op = 6'h2B; func = 6'h00;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      mem_ready = (mem_req && iord) ? 1'b0 : 1'b1;
      #1;
      if (mem_we) seen++;
    end
    check_val("abort.memwr_wait", seen, 2);
    nrst = 1'b0;
    #1;
    check_val("abort.outputs", 32'(all_out), 32'd0);
    check_val("abort.retired", instr_retired, 32'd0);
    exp_ret = 32'd0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check_val("abort.rst_cycle", 32'(all_out), 32'd0);
    @(negedge clk);
    #1;
    check_val("abort.fetch_cycle", 32'({mem_req, iord, mem_we}), 32'b100);
    $display("abort  sw reset while waiting in MEMWR, retired=%0d", instr_retired);

    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    force dut.instr_retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_retired_q;
    exp_ret = 32'hFFFF_FFFF;
    run_instr("j_wrap", 6'h02, 6'h00, 1'b0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcyc_control_fsm.md
# mcyc_control_fsm

Multi-cycle main control unit for the MCycMIPS32 core; drives every datapath strobe and mux select in the top-level datapath from the decoded `op`/`func` fields and the ALU zero flag. A Moore state machine sequences each instruction through fetch/decode/execute/memory/writeback. A valid/ready handshake with instruction/data memory inserts wait states, and a retired-instruction counter supports bring-up on the DE10-Lite LEDs/HEX displays.

## Interface
- No parameters; all encodings come from `mcyc_ctrl_pkg`.
- `clk`  in  1  system clock (MAX10_CLK1_50 at top)
- `nrst`  in  1  asynchronous, active-low reset
- `op`  in  6  instr[31:26] from instruction register
- `func`  in  6  instr[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current access this cycle
- `mem_req` / `mem_we`  out  1 / 1  memory access request / write qualifier
- `ir_we`, `mdr_we`, `rega_we`, `regb_we`, `aluout_we`, `reg_write`, `pc_we`  out  1 each  single-cycle write enables
- `mem_to_reg`, `reg_dst`, `alu_src_a`, `iord`  out  1 each  2:1 selects (0 = ALUOut/rt/PC/PC)
- `alu_src_b`  out  3  0 RegB, 2 signext imm, 3 signext<<2, 4 const 4, 5 zeroext imm
- `pc_src`  out  3  0 ALU result, 1 ALUOut, 2 jump addr, 3 RegA
- `aluop`  out  4  ALU operation (package encoding)
- `illegal`  out  1  sticky; unsupported instruction decoded
- `instr_retired`  out  32  count of completed instructions

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP, JR, HALT.
- RST: entered on reset, all outputs 0; next FETCH unconditionally.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=4, aluop=ADD, pc_src=0. ir_we and pc_we assert only when mem_ready=1; stay in FETCH while mem_ready=0.
- DECODE: rega_we=regb_we=aluout_we=1, alu_src_a=0, alu_src_b=3, aluop=ADD (branch target). Dispatch on op:
  - 0x00 → REXEC, or JR if func=0x08; all-zero instruction (NOP) → FETCH, still retires.
  - 0x23 lw / 0x2B sw → MEMADR; 0x04 beq / 0x05 bne → BRANCH; 0x02 j → JUMP.
  - 0x08/0x09/0x0A/0x0C/0x0D → IEXEC; anything else → HALT.
- REXEC: alu_src_a=1, alu_src_b=0, aluop from func (add/addu, sub/subu, and, or, xor, nor, slt), aluout_we=1. Unsupported func → HALT.
- RWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- IEXEC: alu_src_a=1; alu_src_b=5 for andi/ori, else 2; aluop per op; aluout_we=1. IWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- MEMADR: alu_src_a=1, alu_src_b=2, ADD, aluout_we=1; next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1, mdr_we when mem_ready; waits like FETCH. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEMWR: mem_req=mem_we=1, iord=1; waits for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_we = zero XOR (op==bne).
- JUMP: pc_src=2, pc_we=1. JR: pc_src=3, pc_we=1.
- HALT: illegal=1, all enables 0, absorbing until nrst.
- Final state of each instruction (RWB, IWB, MEMWB, MEMWR with ready, BRANCH, JUMP, JR, NOP DECODE) increments instr_retired; wraps at 2^32 to 0.

## Timing
- State register and counter clocked on clk rising; nrst low forces state RST, counter 0, illegal 0 immediately.
- Outputs combinational from state, plus mem_ready gating on ir_we/pc_we/mdr_we and exit of memory states; no output is registered.
- Zero-wait cycle counts: R/I-type 4, lw 5, sw 4, beq/bne/j/jr 3, NOP 2; each mem_ready=0 cycle adds one.
- mem_req held constant while waiting; mem_ready outside a memory state is ignored.
- Reset mid-instruction: aborts; no enable pulses in the reset cycle or in RST.

## Structure
- `mcyc_ctrl_pkg`: state enum, opcode/funct constants, aluop encodings (AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100), alu_src_b/pc_src select constants.
- Sub-module `mcyc_alu_decode`: combinational op/func → aluop plus supported flag; used by REXEC/IEXEC.

## Test plan
- Reset, mem_ready=1, op=0x00 func=0x20 → states RST,FETCH,DECODE,REXEC,RWB; reg_write=1 with reg_dst=1 in cycle 5; instr_retired=1.
- lw with mem_ready low 2 cycles in FETCH and 1 in MEMRD → 8 cycles total; ir_we and mdr_we each pulse exactly once.
- beq with zero=1 → pc_we=1 pc_src=1 in BRANCH; zero=0 → pc_we=0; bne inverts both cases.
- op=0x3F → HALT, illegal=1, all enables 0 for 100 cycles; nrst pulse → RST, illegal=0.
- nrst asserted in MEMWR while waiting → no mem_we/pc_we afterwards, state RST, counter 0.
- Force instr_retired=0xFFFFFFFF, retire j → counter reads 0.
